// File: rtl/c64pla_select_monitor.sv
// C64 PLA select monitor: synchronises active-low selects, counts activations per channel,
// and freezes the counts into a shadow bank on a 4-phase snapshot handshake.
// Optional glitch detector is built when C64PLA_GLITCH_DET_EN is defined.

module c64pla_sel_chan #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 3
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             sel_async,
  input  logic             count_en,
  input  logic             capture,
  output logic [CNT_W-1:0] cnt_sh,
  output logic             ovf_sh,
  output logic [7:0]       glitch_sh
);
  if (SYNC_STAGES < 2 || MIN_PULSE < 1) begin : g_bad_cfg
    $error("c64pla_sel_chan: SYNC_STAGES must be >= 2 and MIN_PULSE >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_last, act;
  logic [CNT_W-1:0]       live_q, sh_q;
  logic                   live_ovf_q, sh_ovf_q;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign act       = prev_q & ~sync_last;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sel_async};
      prev_q <= sync_last;
    end
  end

  // An activation coinciding with capture belongs to the new window.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      live_q     <= '0;
      live_ovf_q <= 1'b0;
      sh_q       <= '0;
      sh_ovf_q   <= 1'b0;
    end else if (capture) begin
      sh_q       <= live_q;
      sh_ovf_q   <= live_ovf_q;
      live_q     <= (act && count_en) ? CNT_W'(1) : '0;
      live_ovf_q <= 1'b0;
    end else if (act && count_en) begin
      if (live_q == '1) live_ovf_q <= 1'b1;
      else              live_q     <= live_q + 1'b1;
    end
  end

  assign cnt_sh = sh_q;
  assign ovf_sh = sh_ovf_q;

`ifdef C64PLA_GLITCH_DET_EN
  localparam int WW = $clog2(MIN_PULSE + 1);
  logic [WW-1:0] width_q;
  logic [7:0]    gl_live_q, gl_sh_q;
  logic          rise, glitch;

  assign rise   = ~prev_q & sync_last;
  assign glitch = rise && (width_q < WW'(MIN_PULSE));

  // width_q holds the number of cycles the synced select has been low.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      width_q   <= '0;
      gl_live_q <= '0;
      gl_sh_q   <= '0;
    end else begin
      if (!sync_last) begin
        if (width_q != WW'(MIN_PULSE)) width_q <= width_q + 1'b1;
      end else begin
        width_q <= '0;
      end
      if (capture) begin
        gl_sh_q   <= gl_live_q;
        gl_live_q <= glitch ? 8'd1 : 8'd0;
      end else if (glitch && gl_live_q != 8'hFF) begin
        gl_live_q <= gl_live_q + 8'd1;
      end
    end
  end

  assign glitch_sh = gl_sh_q;
`else
  assign glitch_sh = '0;
`endif
endmodule

module c64pla_select_monitor #(
  parameter int NCH         = 8,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 3
) (
  input  logic             clk_i,
  input  logic             rst_override_n,
  input  logic [NCH-1:0]   sel_n_async,
  input  logic             count_en,
  input  logic             snap_req,
  output logic             snap_ack,
  input  logic [2:0]       rd_addr,
  input  logic             rd_glitch,
  output logic [CNT_W-1:0] rd_data,
  output logic [NCH-1:0]   ovf
);
  typedef enum logic [1:0] {IDLE, CAPTURE, ACK} state_t;

  state_t                       state_q, state_d;
  logic                         capture;
  logic [NCH-1:0][CNT_W-1:0]    cnt_sh;
  logic [NCH-1:0][7:0]          gl_sh;
  logic [CNT_W-1:0]             rd_next;

  always_ff @(posedge clk_i) begin
    if (!rst_override_n) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (snap_req) state_d = CAPTURE;
      CAPTURE: state_d = ACK;
      ACK:     if (!snap_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign capture  = (state_q == CAPTURE);
  assign snap_ack = (state_q == ACK);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    c64pla_sel_chan #(
      .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .MIN_PULSE(MIN_PULSE)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_n     (rst_override_n),
      .sel_async (sel_n_async[i]),
      .count_en  (count_en),
      .capture   (capture),
      .cnt_sh    (cnt_sh[i]),
      .ovf_sh    (ovf[i]),
      .glitch_sh (gl_sh[i])
    );
  end

  // Out-of-range addresses fall through to zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NCH; i++)
      if (int'(rd_addr) == i) rd_next = rd_glitch ? CNT_W'(gl_sh[i]) : cnt_sh[i];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_override_n) rd_data <= '0;
    else                 rd_data <= rd_next;
  end
endmodule

// File: tb/tb_c64pla_select_monitor.sv
// Directed + randomized bench for c64pla_select_monitor against a pulse-counting model.
// CNT_W is reduced to 10 so saturation is reachable in a few thousand cycles.
module tb_c64pla_select_monitor;
  localparam int NCH  = 8;
  localparam int CNT_W = 10;
  localparam int SS   = 2;
  localparam int MP   = 3;
  localparam int MAXC = (1 << CNT_W) - 1;
`ifdef C64PLA_GLITCH_DET_EN
  localparam bit GLITCH = 1'b1;
`else
  localparam bit GLITCH = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_override_n = 1'b0;
  logic [NCH-1:0]   sel_n_async = '1;
  logic             count_en = 1'b0;
  logic             snap_req = 1'b0;
  logic             snap_ack;
  logic [2:0]       rd_addr = '0;
  logic             rd_glitch = 1'b0;
  logic [CNT_W-1:0] rd_data;
  logic [NCH-1:0]   ovf;

  int errors = 0;
  int checks = 0;
  int exp_cnt [NCH];
  bit exp_ovf [NCH];
  int exp_gl  [NCH];

  always #5 clk_i = ~clk_i;

  c64pla_select_monitor #(
    .NCH(NCH), .CNT_W(CNT_W), .SYNC_STAGES(SS), .MIN_PULSE(MP)
  ) dut (
    .clk_i          (clk_i),
    .rst_override_n (rst_override_n),
    .sel_n_async    (sel_n_async),
    .count_en       (count_en),
    .snap_req       (snap_req),
    .snap_ack       (snap_ack),
    .rd_addr        (rd_addr),
    .rd_glitch      (rd_glitch),
    .rd_data        (rd_data),
    .ovf            (ovf)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < NCH; c++) begin
      exp_cnt[c] = 0;
      exp_ovf[c] = 1'b0;
      exp_gl[c]  = 0;
    end
  endtask

  // Drive one low pulse on every channel in m; the model counts it by rule.
  task automatic pulse(input logic [NCH-1:0] m, input int lo, input int hi);
    sel_n_async = ~m;
    tick(lo);
    sel_n_async = '1;
    tick(hi);
    for (int c = 0; c < NCH; c++) begin
      if (m[c]) begin
        if (count_en) begin
          if (exp_cnt[c] == MAXC) exp_ovf[c] = 1'b1;
          else                    exp_cnt[c]++;
        end
        if (lo < MP && exp_gl[c] < 255) exp_gl[c]++;
      end
    end
  endtask

  task automatic flush();
    tick(SS + 3);
  endtask

  task automatic snap(input string tag, input bit timing);
    int n;
    snap_req = 1'b1;
    tick();
    if (timing) chk({tag, "_ack_early"}, 32'(snap_ack), 0);
    n = 1;
    while (!snap_ack && n < 10) begin
      tick();
      n++;
    end
    if (timing) chk({tag, "_ack_latency"}, n, 2);
    else        chk({tag, "_ack"}, 32'(snap_ack), 1);
    snap_req = 1'b0;
    tick();
    chk({tag, "_ack_drop"}, 32'(snap_ack), 0);
  endtask

  task automatic read_check(input string tag);
    logic [NCH-1:0] ev;
    for (int c = 0; c < NCH; c++) ev[c] = exp_ovf[c];
    chk({tag, "_ovf"}, 32'(ovf), 32'(ev));
    for (int c = 0; c < NCH; c++) begin
      rd_addr   = 3'(c);
      rd_glitch = 1'b0;
      tick();
      chk($sformatf("%s_cnt%0d", tag, c), 32'(rd_data), exp_cnt[c]);
      rd_glitch = 1'b1;
      tick();
      chk($sformatf("%s_gl%0d", tag, c), 32'(rd_data), GLITCH ? exp_gl[c] : 0);
    end
    rd_glitch = 1'b0;
    clear_model();
  endtask

  initial begin
    logic [NCH-1:0] m;
    clear_model();

    // Reset state
    tick(3);
    chk("rst_ack", 32'(snap_ack), 0);
    chk("rst_rd", 32'(rd_data), 0);
    rst_override_n = 1'b1;
    tick();
    read_check("reset");

    // Five 10-cycle pulses on IOn
    count_en = 1'b1;
    repeat (5) pulse(NCH'(1 << 2), 10, 10);
    flush();
    snap("five", 1'b1);
    read_check("five");

    // Saturation on CASRAMn, then an empty window
    repeat (MAXC + 80) pulse(NCH'(1 << 7), 1, 1);
    flush();
    snap("sat", 1'b0);
    read_check("sat");
    snap("sat2", 1'b0);
    read_check("sat2");

    // Activation on ch 0 landing in the CAPTURE cycle
    sel_n_async[0] = 1'b0;
    tick(SS - 1);
    snap_req = 1'b1;
    tick(2);
    chk("cap_ack", 32'(snap_ack), 1);
    sel_n_async = '1;
    snap_req = 1'b0;
    flush();
    read_check("cap_old");
    exp_cnt[0] = 1;
    snap("cap_new", 1'b0);
    read_check("cap_new");

    // count_en=0 holds counts
    count_en = 1'b0;
    repeat (4) pulse(NCH'(1 << 3), 4, 4);
    flush();
    snap("noen", 1'b0);
    read_check("noen");

    // Reset in ACK abandons the window
    count_en = 1'b1;
    repeat (3) pulse(NCH'(1 << 1), 3, 3);
    flush();
    snap_req = 1'b1;
    tick(2);
    chk("rstack_ack", 32'(snap_ack), 1);
    rst_override_n = 1'b0;
    snap_req = 1'b0;
    tick();
    chk("rstack_drop", 32'(snap_ack), 0);
    rst_override_n = 1'b1;
    clear_model();
    read_check("rstack");

    // Short pulses on KERNALn
    pulse(NCH'(1 << 4), 1, 3);
    pulse(NCH'(1 << 4), 2, 3);
    flush();
    snap("glitch", 1'b0);
    read_check("glitch");

    // Randomized batches, the middle one with counting disabled
    for (int b = 0; b < 3; b++) begin
      count_en = (b != 1);
      for (int r = 0; r < 40; r++) begin
        m = NCH'($urandom);
        pulse(m, $urandom_range(1, 4), $urandom_range(1, 3));
      end
      flush();
    end
    count_en = 1'b1;
    snap("rand", 1'b0);
    read_check("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
